mbist_sequencer: RTL and testbench
==================================

Name: mbist_sequencer

Overview:
On-chip initiator for one Tessent-style MBISTPG controller port group, such as the ROM or SRAM BIST assembly inside the memory wrapper. It drives the controller's EN, ASYNC_RESETN, MEM_RST, BIST_SETUP, SHIFT and SI inputs through a fixed reset / setup / run / status-shift sequence. It monitors GO and DONE, then reports pass, fail or timeout to a software-visible control block. The top level instantiates one sequencer per BIST assembly, and all MBIST signals are synchronous to clk (BIST_CLK is tied to clk).

Parameters:
RST_CYCLES, 8, cycles ASYNC_RESETN is held low and MEM_RST held high in RESET.
SETUP_CYCLES, 4, cycles in SETUP with BIST_SETUP=2'b01.
GO_SETTLE, 4, number of initial RUN cycles during which GO is ignored.
TIMEOUT_CYCLES, 65536, maximum RUN cycles before timeout; must be >= GO_SETTLE+1.
STATUS_LEN, 16, number of SO bits captured in SHIFT (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start_i  in  1  level-sampled start request; ignored unless in IDLE.
- abort_i  in  1  returns the block to IDLE from any state.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse in FINISH.
- pass_o  out  1  result; held until the next accepted start.
- timeout_o  out  1  DONE not seen within TIMEOUT_CYCLES; held until the next accepted start.
- status_o  out  STATUS_LEN  captured SO bits.
- mbistpg_en_o  out  1  to MBISTPG_EN.
- mbistpg_async_resetn_o  out  1  to MBISTPG_ASYNC_RESETN.
- mbistpg_mem_rst_o  out  1  to MBISTPG_MEM_RST.
- bist_setup_o  out  2  to BIST_SETUP.
- bist_setup2_o  out  1  to BIST_SETUP2; constant 0.
- bist_hold_o  out  1  to BIST_HOLD; constant 0.
- bist_shift_o  out  1  to BIST_SHIFT.
- bist_si_o  out  1  to BIST_SI; constant 0.
- mbistpg_go_i  in  1  from MBISTPG_GO.
- mbistpg_done_i  in  1  from MBISTPG_DONE.
- mbistpg_so_i  in  1  from MBISTPG_SO.

Behaviour:
- All MBIST outputs are registered.
- Reset values, also the values in IDLE:
  - en=0, async_resetn=0, mem_rst=0, setup=2'b00, shift=0.
  - busy=0, done=0, pass=0, timeout=0, status=0.
- States: IDLE, RESET, SETUP, RUN, SHIFT, FINISH. One shared cycle counter, cleared on every state entry.
- IDLE:
  - start_i=1 → RESET on the next edge.
  - pass, timeout and status are cleared on that same edge.
  - busy_o=1 from the first RESET cycle.
- RESET: async_resetn=0, mem_rst=1 for exactly RST_CYCLES cycles → SETUP.
- SETUP: async_resetn=1, mem_rst=0, setup=2'b01 for SETUP_CYCLES cycles → RUN.
- RUN: setup=2'b10, en=1; the counter increments every cycle.
  - Once counter >= GO_SETTLE, any cycle with go_i=0 sets a sticky fail flag.
  - The first cycle with done_i=1 latches pass = go_i & ~fail.
  - After that cycle, the next state is SHIFT with the feature enabled, otherwise FINISH.
  - If counter reaches TIMEOUT_CYCLES-1 without done_i → FINISH with timeout=1, pass=0.
  - done_i and timeout in the same cycle: done_i wins; timeout=0.
- SHIFT: en=1, setup=2'b00, shift=1 for STATUS_LEN cycles.
  - SO is sampled each cycle, LSB first: status_o[k] = so_i in the k-th shift cycle.
  - Then → FINISH.
- FINISH: done_o=1 for one cycle; en=0, async_resetn=0, shift=0; → IDLE.
- abort_i=1 in any non-IDLE state → IDLE on the next edge.
  - All MBIST outputs take their reset values.
  - No done pulse; pass=0, timeout=0.
  - Abort has priority over all other transitions.
- start_i while busy: ignored, no effect on the running sequence.
- rst_n low mid-sequence: synchronous return to reset values on the next edge.
- Counter width is $clog2(max(TIMEOUT_CYCLES, RST_CYCLES, SETUP_CYCLES, STATUS_LEN)+1); the counter never wraps.

Optional Feature:
MBIST_SEQ_STATUS_SHIFT_EN
- Defined: the SHIFT state exists and status_o captures SO as described above.
- Undefined: no SHIFT state, RUN goes directly to FINISH, status_o is tied to 0, bist_shift_o is tied to 0, and STATUS_LEN is unused.

Test Plan:
1. Pass run: model raises DONE 100 RUN cycles after EN with GO=1 → en rises 12 cycles after start is accepted; done_o pulses once; pass_o=1, timeout_o=0.
2. Transient fail: GO=0 for one cycle at RUN cycle 50, then GO=1 and DONE at 100 → pass_o=0, timeout_o=0. A GO=0 glitch at RUN cycle 2 (within the settle window) with GO=1 thereafter → pass_o=1.
3. Timeout with TIMEOUT_CYCLES=256 and DONE never asserted → done_o pulses after 256 RUN cycles; timeout_o=1, pass_o=0, en deasserted.
4. Abort mid-RUN at cycle 30 → next cycle: busy_o=0, en=0, async_resetn=0; done_o never pulses. A new start then runs a full sequence normally.
5. Start while busy: pulse start_i during SETUP and during RUN → sequence timing is unchanged and exactly one done pulse occurs.
6. With the feature enabled, STATUS_LEN=16, SO driving 16'hA5C3 LSB first → status_o=16'hA5C3 and bist_shift_o high for exactly 16 cycles. Also drive rst_n low during SHIFT → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/mbist_sequencer.sv
// rtl/mbist_sequencer.sv - reset/setup/run/status-shift initiator for one MBISTPG controller port group
// Optional status capture through BIST_SHIFT/SO is enabled by defining MBIST_SEQ_STATUS_SHIFT_EN.
module mbist_sequencer #(
  parameter int RST_CYCLES     = 8,
  parameter int SETUP_CYCLES   = 4,
  parameter int GO_SETTLE      = 4,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int STATUS_LEN     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [STATUS_LEN-1:0] status_o,
  output logic                  mbistpg_en_o,
  output logic                  mbistpg_async_resetn_o,
  output logic                  mbistpg_mem_rst_o,
  output logic [1:0]            bist_setup_o,
  output logic                  bist_setup2_o,
  output logic                  bist_hold_o,
  output logic                  bist_shift_o,
  output logic                  bist_si_o,
  input  logic                  mbistpg_go_i,
  input  logic                  mbistpg_done_i,
  input  logic                  mbistpg_so_i
);

  // One counter serves every phase, so it must hold the longest phase length.
  localparam int MAX_RS  = (RST_CYCLES > SETUP_CYCLES) ? RST_CYCLES : SETUP_CYCLES;
  localparam int MAX_RSL = (MAX_RS > STATUS_LEN) ? MAX_RS : STATUS_LEN;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > MAX_RSL) ? TIMEOUT_CYCLES : MAX_RSL;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_CNT = CW'(GO_SETTLE);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT    = CW'(CNT_MAX);
`ifdef MBIST_SEQ_STATUS_SHIFT_EN
  localparam logic [CW-1:0] SHIFT_LAST = CW'(STATUS_LEN - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_SETUP  = 3'd2,
    S_RUN    = 3'd3,
    S_SHIFT  = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic            fail_q;
  logic            accept;
  logic            abort_hit;
  logic            run_hit;
  logic            run_tmo;

  logic            busy_d;
  logic            done_d;
  logic            en_d;
  logic            arst_n_d;
  logic            mem_rst_d;
  logic [1:0]      setup_d;

  logic            busy_q;
  logic            done_q;
  logic            en_q;
  logic            arst_n_q;
  logic            mem_rst_q;
  logic [1:0]      setup_q;
  logic            pass_q;
  logic            timeout_q;

  assign accept = (state_q == S_IDLE) && start_i;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection plus decode of the registered controller pins from the next state.
  always_comb begin
    state_d   = state_q;
    run_hit   = 1'b0;
    run_tmo   = 1'b0;
    abort_hit = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    en_d      = 1'b0;
    arst_n_d  = 1'b0;
    mem_rst_d = 1'b0;
    setup_d   = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RESET;
      end
      S_RESET: begin
        if (cnt_q == RST_LAST) state_d = S_SETUP;
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        // DONE in the final allowed cycle still counts as a completed run.
        if (mbistpg_done_i) begin
          run_hit = 1'b1;
`ifdef MBIST_SEQ_STATUS_SHIFT_EN
          state_d = S_SHIFT;
`else
          state_d = S_FINISH;
`endif
        end else if (cnt_q == TMO_LAST) begin
          run_tmo = 1'b1;
          state_d = S_FINISH;
        end
      end
`ifdef MBIST_SEQ_STATUS_SHIFT_EN
      S_SHIFT: begin
        if (cnt_q == SHIFT_LAST) state_d = S_FINISH;
      end
`endif
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort beats every other transition and discards any result from this cycle.
    if (abort_i && (state_q != S_IDLE)) begin
      abort_hit = 1'b1;
      run_hit   = 1'b0;
      run_tmo   = 1'b0;
      state_d   = S_IDLE;
    end

    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_RESET: begin
        mem_rst_d = 1'b1;
      end
      S_SETUP: begin
        arst_n_d = 1'b1;
        setup_d  = 2'b01;
      end
      S_RUN: begin
        arst_n_d = 1'b1;
        setup_d  = 2'b10;
        en_d     = 1'b1;
      end
      S_SHIFT: begin
        arst_n_d = 1'b1;
        en_d     = 1'b1;
      end
      S_FINISH: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = busy_d;
      end
    endcase
  end

  // Registered controller pins and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      en_q      <= 1'b0;
      arst_n_q  <= 1'b0;
      mem_rst_q <= 1'b0;
      setup_q   <= 2'b00;
    end else begin
      busy_q    <= busy_d;
      done_q    <= done_d;
      en_q      <= en_d;
      arst_n_q  <= arst_n_d;
      mem_rst_q <= mem_rst_d;
      setup_q   <= setup_d;
    end
  end

  // Phase counter restarts on each state entry; sticky GO failure tracked over the run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      fail_q <= 1'b0;
    end else begin
      if ((state_d != state_q) || (state_q == S_IDLE)) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_SAT) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == S_IDLE) begin
        fail_q <= 1'b0;
      end else if ((state_q == S_RUN) && (cnt_q >= SETTLE_CNT) && !mbistpg_go_i) begin
        fail_q <= 1'b1;
      end
    end
  end

  // Result flags: cleared on a new start or an abort, latched when the run ends.
  always_ff @(posedge clk) begin
    if (!rst_n || accept || abort_hit) begin
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (run_hit) begin
      pass_q    <= mbistpg_go_i & ~fail_q;
      timeout_q <= 1'b0;
    end else if (run_tmo) begin
      pass_q    <= 1'b0;
      timeout_q <= 1'b1;
    end
  end

`ifdef MBIST_SEQ_STATUS_SHIFT_EN
  logic [STATUS_LEN-1:0] status_q;
  logic                  shift_q;

  // Shift-enable pin, high exactly while in SHIFT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= 1'b0;
    end else begin
      shift_q <= (state_d == S_SHIFT);
    end
  end

  // Capture SO LSB first: the k-th shift cycle lands in bit k.
  always_ff @(posedge clk) begin
    if (!rst_n || accept || abort_hit) begin
      status_q <= '0;
    end else if (state_q == S_SHIFT) begin
      for (int k = 0; k < STATUS_LEN; k++) begin
        if (cnt_q == CW'(k)) status_q[k] <= mbistpg_so_i;
      end
    end
  end

  assign status_o     = status_q;
  assign bist_shift_o = shift_q;
`else
  logic unused_so;
  assign unused_so    = mbistpg_so_i;
  assign status_o     = '0;
  assign bist_shift_o = 1'b0;
`endif

  assign busy_o                 = busy_q;
  assign done_o                 = done_q;
  assign pass_o                 = pass_q;
  assign timeout_o              = timeout_q;
  assign mbistpg_en_o           = en_q;
  assign mbistpg_async_resetn_o = arst_n_q;
  assign mbistpg_mem_rst_o      = mem_rst_q;
  assign bist_setup_o           = setup_q;
  assign bist_setup2_o          = 1'b0;
  assign bist_hold_o            = 1'b0;
  assign bist_si_o              = 1'b0;

endmodule

// File: tb/tb_mbist_sequencer.sv
// tb/tb_mbist_sequencer.sv - randomized self-checking bench for mbist_sequencer against a timeline model
module tb_mbist_sequencer;

  localparam int RST_C  = 8;
  localparam int SET_C  = 4;
  localparam int SETTLE = 4;
  localparam int TO     = 256;
  localparam int SL     = 16;
  localparam int RS     = RST_C + SET_C;
`ifdef MBIST_SEQ_STATUS_SHIFT_EN
  localparam int SHIFT_LEN = SL;
`else
  localparam int SHIFT_LEN = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic          abort_i;
  logic          busy_o;
  logic          done_o;
  logic          pass_o;
  logic          timeout_o;
  logic [SL-1:0] status_o;
  logic          mbistpg_en_o;
  logic          mbistpg_async_resetn_o;
  logic          mbistpg_mem_rst_o;
  logic [1:0]    bist_setup_o;
  logic          bist_setup2_o;
  logic          bist_hold_o;
  logic          bist_shift_o;
  logic          bist_si_o;
  logic          mbistpg_go_i;
  logic          mbistpg_done_i;
  logic          mbistpg_so_i;

  int n_checks = 0;
  int n_fail   = 0;

  mbist_sequencer #(
    .RST_CYCLES     (RST_C),
    .SETUP_CYCLES   (SET_C),
    .GO_SETTLE      (SETTLE),
    .TIMEOUT_CYCLES (TO),
    .STATUS_LEN     (SL)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .start_i                (start_i),
    .abort_i                (abort_i),
    .busy_o                 (busy_o),
    .done_o                 (done_o),
    .pass_o                 (pass_o),
    .timeout_o              (timeout_o),
    .status_o               (status_o),
    .mbistpg_en_o           (mbistpg_en_o),
    .mbistpg_async_resetn_o (mbistpg_async_resetn_o),
    .mbistpg_mem_rst_o      (mbistpg_mem_rst_o),
    .bist_setup_o           (bist_setup_o),
    .bist_setup2_o          (bist_setup2_o),
    .bist_hold_o            (bist_hold_o),
    .bist_shift_o           (bist_shift_o),
    .bist_si_o              (bist_si_o),
    .mbistpg_go_i           (mbistpg_go_i),
    .mbistpg_done_i         (mbistpg_done_i),
    .mbistpg_so_i           (mbistpg_so_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [28:0] obs_vec();
    return {busy_o, mbistpg_en_o, mbistpg_async_resetn_o, mbistpg_mem_rst_o, bist_setup_o,
            bist_shift_o, done_o, pass_o, timeout_o, bist_setup2_o, bist_hold_o, bist_si_o, status_o};
  endfunction

  // One accepted start, then a cycle-by-cycle comparison against the phase timeline.
  // done_at/go_low_at are RUN-cycle indices (-1 = never); kill_t is a cycle index after acceptance.
  task automatic run_seq(input string name, input int done_at, input int go_low_at, input int kill_t,
                         input bit kill_rst, input logic [15:0] so_word, input int spur_a, input int spur_b);
    int          len;
    int          run_end;
    int          t_fin;
    int          t_last;
    int          k;
    int          j;
    int          n;
    int          lim;
    int          en_rise;
    int          dones;
    int          shifts;
    int          bad_t;
    bit          exp_to;
    bit          exp_pass;
    bit          bad;
    logic [15:0] smask;
    logic [28:0] got;
    logic [28:0] exp;
    logic [28:0] bad_got;
    logic [28:0] bad_exp;

    exp_to   = (done_at < 0) || (done_at >= TO);
    len      = exp_to ? TO : done_at + 1;
    exp_pass = !exp_to && !((go_low_at >= 0) &&
               ((go_low_at == done_at) || ((go_low_at >= SETTLE) && (go_low_at < done_at))));
    run_end  = RS + len;
    t_fin    = run_end + SHIFT_LEN;
    t_last   = (kill_t >= 0) ? kill_t + 2 : t_fin + 2;
    en_rise  = -1;
    dones    = 0;
    shifts   = 0;
    bad      = 1'b0;
    bad_t    = -1;
    bad_got  = '0;
    bad_exp  = '0;
    got      = '0;
    exp      = '0;

    @(negedge clk);
    start_i        = 1'b1;
    abort_i        = 1'b0;
    rst_n          = 1'b1;
    mbistpg_go_i   = 1'b0;
    mbistpg_done_i = 1'b0;

    for (int t = 0; t <= t_last; t++) begin
      @(negedge clk);
      if ((kill_t >= 0) && (t > kill_t)) begin
        exp = '0;
      end else begin
        n = t - run_end;
        if (n < 0) n = 0;
        if (n > SHIFT_LEN) n = SHIFT_LEN;
        smask = (n >= 16) ? 16'hFFFF : 16'((32'd1 << n) - 32'd1);
        exp = {t <= t_fin, (t >= RS) && (t < t_fin), (t >= RST_C) && (t < t_fin), t < RST_C,
               ((t >= RST_C) && (t < RS)) ? 2'b01 : (((t >= RS) && (t < run_end)) ? 2'b10 : 2'b00),
               (t >= run_end) && (t < t_fin), t == t_fin,
               (t >= run_end) && exp_pass, (t >= run_end) && exp_to, 3'b000, so_word & smask};
      end
      got = obs_vec();
      if (!bad && (got !== exp)) begin
        bad     = 1'b1;
        bad_t   = t;
        bad_got = got;
        bad_exp = exp;
      end
      if (mbistpg_en_o && (en_rise < 0)) en_rise = t;
      if (done_o) dones++;
      if (bist_shift_o) shifts++;

      k              = t - RS;
      j              = t - run_end;
      start_i        = (t == spur_a) || (t == spur_b);
      mbistpg_go_i   = (k >= 0) && (k < len) && (k != go_low_at);
      mbistpg_done_i = (done_at >= 0) && (k >= done_at);
      mbistpg_so_i   = ((j >= 0) && (j < 16)) ? so_word[j] : 1'($urandom_range(0, 1));
      abort_i        = (t == kill_t) && !kill_rst;
      rst_n          = !((t == kill_t) && kill_rst);
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    rst_n   = 1'b1;

    if (bad) check_eq($sformatf("%s:timeline@%0d", name, bad_t), 64'(bad_got), 64'(bad_exp));
    else     check_eq($sformatf("%s:timeline", name), 64'(got), 64'(exp));

    check_eq({name, ":en_rise"}, 64'(en_rise), 64'(((kill_t < 0) || (kill_t >= RS)) ? RS : -1));
    check_eq({name, ":done_pulses"}, 64'(dones), 64'((kill_t < 0) ? 1 : 0));
    lim = (kill_t < 0) ? t_fin : ((kill_t + 1 < t_fin) ? kill_t + 1 : t_fin);
    check_eq({name, ":shift_cycles"}, 64'(shifts), 64'((lim > run_end) ? lim - run_end : 0));
    check_eq({name, ":pass"}, 64'(pass_o), 64'((kill_t < 0) && exp_pass));
    check_eq({name, ":timeout"}, 64'(timeout_o), 64'((kill_t < 0) && exp_to));
    check_eq({name, ":status"}, 64'(status_o), 64'(((kill_t < 0) && (SHIFT_LEN > 0)) ? so_word : 16'h0));
  endtask

  initial begin
    int          d;
    int          g;
    int          kt;
    int          lr;
    int          tf;
    int          lim;
    int          sa;
    int          sb;
    bit          kr;
    logic [15:0] sw;

    rst_n          = 1'b0;
    start_i        = 1'b0;
    abort_i        = 1'b0;
    mbistpg_go_i   = 1'b0;
    mbistpg_done_i = 1'b0;
    mbistpg_so_i   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_state", 64'(obs_vec()), 64'h0);
    start_i = 1'b1;
    @(negedge clk);
    check_eq("start_in_reset", 64'(obs_vec()), 64'h0);
    start_i = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    check_eq("idle_after_reset", 64'(obs_vec()), 64'h0);

    run_seq("pass",          100, -1, -1, 1'b0, 16'hA5C3, -1, -1);
    run_seq("glitch50",      100, 50, -1, 1'b0, 16'h1234, -1, -1);
    run_seq("glitch2",       100,  2, -1, 1'b0, 16'hFFFF, -1, -1);
    run_seq("settle_edge",   100,  4, -1, 1'b0, 16'h0001, -1, -1);
    run_seq("settle_inside", 100,  3, -1, 1'b0, 16'h8000, -1, -1);
    run_seq("timeout",        -1, -1, -1, 1'b0, 16'h5A5A, -1, -1);
    run_seq("done_last",     255, -1, -1, 1'b0, 16'hC3A5, -1, -1);
    run_seq("done_last_go0", 255, 255, -1, 1'b0, 16'h00FF, -1, -1);
    run_seq("done_first",      0, -1, -1, 1'b0, 16'h0F0F, -1, -1);
    run_seq("abort_run30",   100, -1, RS + 30, 1'b0, 16'hBEEF, -1, -1);
    run_seq("after_abort",   100, -1, -1, 1'b0, 16'hA5C3, -1, -1);
    run_seq("abort_reset",   100, -1, 3, 1'b0, 16'h1111, -1, -1);
    run_seq("start_busy",    100, -1, -1, 1'b0, 16'h2222, RST_C + 1, RS + 28);
    run_seq("rst_mid",       100, -1, (SHIFT_LEN > 0) ? RS + 101 + 5 : RS + 60, 1'b1, 16'hA5C3, -1, -1);
    run_seq("after_rst",     100, -1, -1, 1'b0, 16'hA5C3, -1, -1);

    for (int i = 0; i < 16; i++) begin
      d  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 300));
      lr = ((d < 0) || (d >= TO)) ? TO : d + 1;
      tf = RS + lr + SHIFT_LEN;
      g  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, lr - 1));
      kt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, tf - 1)) : -1;
      kr = 1'($urandom_range(0, 1));
      sw = 16'($urandom_range(0, 65535));
      lim = (kt >= 0) ? kt : tf;
      sa = (lim >= 2) ? int'($urandom_range(1, lim - 1)) : -1;
      sb = (lim >= 2) ? int'($urandom_range(1, lim - 1)) : -1;
      run_seq($sformatf("rand%0d", i), d, g, kt, kr, sw, sa, sb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
